binary_to_bcd_seq: RTL and testbench
====================================

BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning binary input width in bits (legal range 4..16).
REQ-002 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request conversion of bin_in; sampled only in IDLE.
REQ-005 SHALL have port bin_in  input  IN_W  unsigned binary value to convert.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when a new result is on SEG3..SEG0/ovf.
REQ-008 SHALL have ports SEG3, SEG2, SEG1, SEG0  output  4 each  BCD thousands, hundreds, tens and ones digits; drive the 4-digit hex display nibble inputs directly.
REQ-009 SHALL have port ovf  output  1  high when the result's ten-thousands digit is nonzero.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-011 IDLE with start=1 at a rising edge: SHALL capture bin_in into the shift register, clear the 20-bit BCD accumulator, load the iteration counter with IN_W, and go to SHIFT.
REQ-012 SHIFT, each cycle: SHALL add 3 to every accumulator digit >=5, then shift {accumulator, shift register} left one bit and decrement the counter.
REQ-013 SHIFT: after the IN_W-th shift SHALL go to DONE.
REQ-014 DONE: SHALL register accumulator digits 3..0 into SEG3..SEG0, set ovf = (digit 4 != 0), pulse done for exactly that one cycle, and return to IDLE.
REQ-015 Latency: if start is sampled at edge N, done and new outputs SHALL be visible after edge N+IN_W+1 (17 cycles for IN_W=16).
REQ-016 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; it rises the cycle after start is accepted.
REQ-017 start while busy=1, including during DONE, SHALL be ignored with no queuing.
REQ-018 start held high continuously SHALL start a new conversion on each IDLE cycle, giving one conversion per IN_W+2 cycles.
REQ-019 SEG3..SEG0 and ovf SHALL hold the last completed result between conversions and SHALL never show intermediate accumulator values.
REQ-020 Overflow (value > 9999): outputs SHALL show the low four digits with ovf=1, e.g. 12345 -> 2,3,4,5, ovf=1.
REQ-021 bin_in changes after the accept edge SHALL NOT affect the conversion in progress.
REQ-022 The accumulator SHALL be 5 digits (20 bits), so no digit ever exceeds 9 for any IN_W <= 16.

Reset
REQ-023 Reset_n=0 SHALL immediately force IDLE, with busy=0, done=0, SEG3..SEG0=0, ovf=0, and the counter and all internal registers cleared.
REQ-024 Reset asserted mid-conversion SHALL abort it with no done pulse; outputs SHALL read 0 after release.
REQ-025 The first start after Reset_n release SHALL be accepted at the first rising edge where Reset_n=1 and start=1.

Structure
REQ-026 Shared package bcd_pkg SHALL hold the FSM state enum, NUM_DIGITS=5, DIGIT_W=4, and the add-3 threshold constant (5).
REQ-027 Sub-module bcd_digit_adj (combinational: 4-bit digit in, digit+3 if >=5 else unchanged out) SHALL be instantiated once per accumulator digit.
REQ-028 The output digit order (SEG3 most significant) SHALL match the display multiplexer's nibble mapping, leftmost = SEG3.

Verification
REQ-029 bin_in=0x04D2 (1234), start one cycle -> done 17 cycles later; SEG3..0=1,2,3,4; ovf=0; busy high for cycles 1..17.
REQ-030 bin_in=0 -> SEG=0,0,0,0, ovf=0; then bin_in=9999 -> SEG=9,9,9,9, ovf=0.
REQ-031 bin_in=0xFFFF (65535) -> SEG=5,5,3,5, ovf=1; then 10000 -> SEG=0,0,0,0, ovf=1.
REQ-032 start with 1234, then start pulsed with 5678 at cycles 5 and 17 -> both ignored; a single done pulse; result 1,2,3,4.
REQ-033 Reset_n low at cycle 8 of a 4321 conversion -> busy=0, done never pulses, SEG=0,0,0,0, ovf=0; the next start with 42 -> 0,0,4,2 after 17 cycles.
REQ-034 Random 16-bit values with start held high (back-to-back conversions) -> each done result equals the value mod 10000 per digit, ovf = (value > 9999), done period 18 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int NUM_DIGITS = 5;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADD3_MIN = 4'd5;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to digits of 5 or more
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);
  always_comb q = d >= ADD3_MIN ? d + DIGIT_W'(3) : d;
endmodule

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: one-bit-per-cycle double-dabble converter with registered 4-digit display outputs
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  output logic            busy,
  output logic            done,
  output logic [3:0]      SEG3,
  output logic [3:0]      SEG2,
  output logic [3:0]      SEG1,
  output logic [3:0]      SEG0,
  output logic            ovf
);
  state_t state, state_nx;
  logic [IN_W-1:0] sr;
  logic [NUM_DIGITS*DIGIT_W-1:0] acc, acc_adj;
  logic [4:0] cnt;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(acc[i*DIGIT_W +: DIGIT_W]), .q(acc_adj[i*DIGIT_W +: DIGIT_W]));
  end
  always_comb begin
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == 5'd1 ? DONE : SHIFT) : IDLE;
    busy = state != IDLE;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  // Display outputs only update on leaving DONE, so intermediate sums never reach them
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      done <= 1'b0;
      {SEG3, SEG2, SEG1, SEG0} <= '0;
      ovf <= 1'b0;
    end else begin
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          sr <= bin_in;
          acc <= '0;
          cnt <= 5'(IN_W);
        end
        SHIFT: begin
          {acc, sr} <= {acc_adj, sr} << 1;
          cnt <= cnt - 5'd1;
        end
        DONE: begin
          {SEG3, SEG2, SEG1, SEG0} <= acc[15:0];
          ovf <= |acc[19:16];
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: directed self-checking bench for binary_to_bcd_seq
module tb_binary_to_bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] bin_in = '0;
  logic busy, done, ovf;
  logic [3:0] seg3, seg2, seg1, seg0;
  int total = 0;
  int passed = 0;

  binary_to_bcd_seq #(.IN_W(16)) dut (
    .Clk(clk), .Reset_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done),
    .SEG3(seg3), .SEG2(seg2), .SEG1(seg1), .SEG0(seg0), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else passed++;
  endtask

  function automatic logic [16:0] model(input int v);
    int m;
    m = v % 10000;
    return {v > 9999, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Accept at the next edge, then expect 17 busy cycles and a done pulse right after
  task automatic run(input string tag, input logic [15:0] val, input logic [15:0] exp_seg,
                     input logic exp_ovf, input bit poke);
    int bad;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    bin_in = val;
    @(negedge clk);
    start = 1'b0;
    bin_in = 16'hA5A5;
    for (int k = 1; k <= 16; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clk);
      start = 1'b0;
      if (poke && (k == 4 || k == 16)) begin
        start = 1'b1;
        bin_in = 16'd5678;
      end
    end
    if (busy !== 1'b1 || done !== 1'b0) bad++;
    check({tag, " busy window"}, bad, 0);
    @(negedge clk);
    start = 1'b0;
    check({tag, " done"}, done, 1'b1);
    check({tag, " seg"}, {seg3, seg2, seg1, seg0}, exp_seg);
    check({tag, " ovf"}, ovf, exp_ovf);
    check({tag, " busy idle"}, busy, 1'b0);
    @(negedge clk);
    check({tag, " done single"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int bad;
    logic [15:0] vals [7];
    logic [16:0] m;
    #2;
    check("reset outputs", {busy, done, ovf, seg3, seg2, seg1, seg0}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("1234", 16'd1234, 16'h1234, 1'b0, 1'b0);
    run("zero", 16'd0, 16'h0000, 1'b0, 1'b0);
    run("9999", 16'd9999, 16'h9999, 1'b0, 1'b0);
    run("65535", 16'hFFFF, 16'h5535, 1'b1, 1'b0);
    run("10000", 16'd10000, 16'h0000, 1'b1, 1'b0);
    run("ignored starts", 16'd1234, 16'h1234, 1'b0, 1'b1);
    check("hold after idle", {seg3, seg2, seg1, seg0, ovf}, {16'h1234, 1'b0});

    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort outputs", {busy, done, ovf, seg3, seg2, seg1, seg0}, '0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort no done", bad, 0);
    check("abort seg", {seg3, seg2, seg1, seg0, ovf}, '0);
    run("42", 16'd42, 16'h0042, 1'b0, 1'b0);

    vals[0] = 16'd9999;
    vals[1] = 16'd10000;
    for (int j = 2; j < 7; j++) vals[j] = 16'($urandom);
    @(negedge clk);
    start = 1'b1;
    bin_in = vals[0];
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      bin_in = vals[j+1];
      bad = 0;
      repeat (16) begin
        if (done !== 1'b0) bad++;
        @(negedge clk);
      end
      if (done !== 1'b0) bad++;
      check($sformatf("b2b%0d gap", j), bad, 0);
      @(negedge clk);
      m = model(int'(vals[j]));
      check($sformatf("b2b%0d done", j), done, 1'b1);
      check($sformatf("b2b%0d result", j), {ovf, seg3, seg2, seg1, seg0}, m);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
